// File: rtl/chk_pkg.sv
// chk_pkg: shared types and helpers for the checker error-report scheduler.
`default_nettype none

package chk_pkg;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  localparam int CODE_W_DEF = 8;
  typedef logic [CODE_W_DEF-1:0] err_code_t;

  function automatic int src_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/chk_rr_pick.sv
// chk_rr_pick: combinational round-robin picker, first request at or after ptr wins.
`default_nettype none

module chk_rr_pick
  import chk_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int SRC_W = src_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SRC_W-1:0] ptr,
  output logic             gnt_vld,
  output logic [SRC_W-1:0] gnt_idx
);

  logic [SRC_W:0]   pos;
  logic [SRC_W-1:0] idx;

  // Scan from the farthest offset down so the nearest request overwrites the result.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    pos     = '0;
    idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (SRC_W+1)'(k);
      if (pos >= (SRC_W+1)'(NREQ)) begin
        pos = pos - (SRC_W+1)'(NREQ);
      end
      idx = pos[SRC_W-1:0];
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/chk_err_sched.sv
// chk_err_sched: buffers one error event per checker, round-robins them onto a
// valid/ready log channel, counts errors (saturating) and raises stop_req.
`default_nettype none

module chk_err_sched
  import chk_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int CODE_W  = 8,
  parameter int CNT_W   = 16,
  parameter int MAX_ERR = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        err_valid,
  input  logic [NREQ*CODE_W-1:0] err_code,
  input  logic                   clr,
  output logic                   log_valid,
  input  logic                   log_ready,
  output logic [src_w(NREQ)-1:0] log_src,
  output logic [CODE_W-1:0]      log_code,
  output logic [NREQ-1:0]        overflow,
  output logic [CNT_W-1:0]       err_count,
  output logic                   stop_req
);

  localparam int SRC_W = src_w(NREQ);
  localparam int PW    = $clog2(NREQ + 1);
  localparam int SUM_W = CNT_W + PW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREQ-1:0]   pend_q, pend_d;
  logic [CODE_W-1:0] pend_code_q [NREQ];
  logic [NREQ-1:0]   cap, drop, drain;
  logic [NREQ-1:0]   ovf_q, ovf_d;

  logic              vld_q, vld_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [SRC_W-1:0]  ptr_q, ptr_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_base;
  logic [PW-1:0]     pop;
  logic [SUM_W-1:0]  sum;
  logic              hit;
  state_e            state_q, state_d;

  logic              load;
  logic              gnt_vld;
  logic [SRC_W-1:0]  gnt_idx;

  chk_rr_pick #(
    .NREQ  (NREQ),
    .SRC_W (SRC_W)
  ) u_pick (
    .req     (pend_q),
    .ptr     (ptr_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // A slot that drains this cycle can accept a new event in the same cycle.
  always_comb begin
    load  = !vld_q || log_ready;
    drain = '0;
    if (load && gnt_vld) begin
      drain[gnt_idx] = 1'b1;
    end
    cap    = err_valid & (~pend_q | drain);
    drop   = err_valid & pend_q & ~drain;
    pend_d = err_valid | (pend_q & ~drain);
    ovf_d  = clr ? '0 : (ovf_q | drop);
  end

  always_comb begin
    vld_d  = vld_q;
    src_d  = src_q;
    code_d = code_q;
    ptr_d  = ptr_q;
    if (load) begin
      vld_d = gnt_vld;
      if (gnt_vld) begin
        src_d  = gnt_idx;
        code_d = pend_code_q[gnt_idx];
        ptr_d  = (gnt_idx == SRC_W'(NREQ - 1)) ? '0 : (gnt_idx + SRC_W'(1));
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NREQ; i++) begin
      pop = pop + PW'(err_valid[i]);
    end
    cnt_base = clr ? '0 : cnt_q;
    sum      = SUM_W'(cnt_base) + SUM_W'(pop);
    cnt_d    = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    hit      = (MAX_ERR != 0) && (64'(cnt_d) >= 64'(MAX_ERR));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (hit) state_d = ST_HALT;
      ST_HALT: if (clr && !hit) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      ovf_q  <= '0;
      vld_q  <= 1'b0;
      src_q  <= '0;
      code_q <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < NREQ; i++) begin
        pend_code_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      vld_q  <= vld_d;
      src_q  <= src_d;
      code_q <= code_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < NREQ; i++) begin
        if (cap[i]) begin
          pend_code_q[i] <= err_code[i*CODE_W +: CODE_W];
        end
      end
    end
  end

  assign log_valid = vld_q;
  assign log_src   = src_q;
  assign log_code  = code_q;
  assign overflow  = ovf_q;
  assign err_count = cnt_q;
  assign stop_req  = (state_q == ST_HALT);

endmodule

`default_nettype wire
